traffic_phase_controller: RTL

Phase sequencer for the intersection. It consumes a one-cycle `tick` enable and runs a loadable per-phase countdown. It drives the north-south and east-west signal heads, plus an optional pedestrian walk phase. It sits between the clock-divider tick source and the LED/display outputs, and exposes the live remaining count for the seven-segment display.

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/traffic_phase_controller_phase_timer.sv | 44 ++++
 rtl/traffic_phase_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase sequencer: phase encoding,
// signal-head colour constants, direction enum and light decode helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } dir_t;

  // Signal-head encoding is {R,Y,G}, one-hot.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // North-south head colour for a given phase; red whenever NS is not active.
  function automatic logic [2:0] ns_light_of(input phase_t p);
    logic [2:0] l;
    case (p)
      NS_GREEN:  l = LIGHT_GRN;
      NS_YELLOW: l = LIGHT_YEL;
      default:   l = LIGHT_RED;
    endcase
    return l;
  endfunction

  // East-west head colour for a given phase; red whenever EW is not active.
  function automatic logic [2:0] ew_light_of(input phase_t p);
    logic [2:0] l;
    case (p)
      EW_GREEN:  l = LIGHT_GRN;
      EW_YELLOW: l = LIGHT_YEL;
      default:   l = LIGHT_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// Loadable down-counter used as the per-phase countdown. A load wins over a
// decrement; the count saturates at zero and never wraps. done flags the
// tick that lands on an already-zero count, i.e. the last tick of a phase.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int               CNT_W     = 6,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             InputClk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remaining,
  output logic             done
);

  logic [CNT_W-1:0] remaining_q;
  logic [CNT_W-1:0] remaining_d;

  // Next count: reload on phase change, otherwise step down on each tick until zero.
  always_comb begin
    remaining_d = remaining_q;
    if (load) begin
      remaining_d = load_val;
    end else if (tick && (remaining_q != '0)) begin
      remaining_d = remaining_q - 1'b1;
    end
  end

  // Count register; reset value matches the phase the controller resets into.
  always_ff @(posedge InputClk) begin
    if (reset) begin
      remaining_q <= RESET_VAL;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign remaining = remaining_q;
  assign done      = tick && (remaining_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: NS green/yellow, all-red, EW green/yellow,
// all-red, with an optional pedestrian walk inserted after an all-red phase.
// Optional feature macro: TRAFFIC_PED_EN (walk phase and request latch).
// Without it ped_req is ignored and walk/ped_ack stay low.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 15,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 8,
  parameter int CNT_W        = 6
) (
  input  logic             InputClk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_ack,
  output logic [CNT_W-1:0] remaining
);

  // Durations are stored minus one so a full 2^CNT_W tick phase still fits.
  localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_TICKS - 1);

  function automatic logic [CNT_W-1:0] duration_m1(input phase_t p);
    logic [CNT_W-1:0] d;
    case (p)
      NS_GREEN, EW_GREEN:   d = GREEN_M1;
      NS_YELLOW, EW_YELLOW: d = YELLOW_M1;
      PED_WALK:             d = WALK_M1;
      default:              d = ALLRED_M1;
    endcase
    return d;
  endfunction

  phase_t     state_q, state_d;
  dir_t       next_dir_q, next_dir_d;
  logic       ped_pending_q, ped_pending_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;
  logic       walk_q, walk_d;
  logic       ped_ack_q, ped_ack_d;
  logic       enter_walk;
  logic       timer_done;

  // The timer reloads on exactly the edge the FSM changes phase.
  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (ALLRED_M1)
  ) u_timer (
    .InputClk  (InputClk),
    .reset     (reset),
    .tick      (tick),
    .load      (timer_done),
    .load_val  (duration_m1(state_d)),
    .remaining (remaining),
    .done      (timer_done)
  );

  // Phase sequencing: advance only on the last tick of the current phase.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    enter_walk = 1'b0;
    if (timer_done) begin
      case (state_q)
        NS_GREEN:  state_d = NS_YELLOW;
        NS_YELLOW: state_d = ALL_RED_1;
        ALL_RED_1: begin
          if (ped_pending_q) begin
            state_d    = PED_WALK;
            next_dir_d = EW;
            enter_walk = 1'b1;
          end else begin
            state_d = EW_GREEN;
          end
        end
        EW_GREEN:  state_d = EW_YELLOW;
        EW_YELLOW: state_d = ALL_RED_2;
        ALL_RED_2: begin
          if (ped_pending_q) begin
            state_d    = PED_WALK;
            next_dir_d = NS;
            enter_walk = 1'b1;
          end else begin
            state_d = NS_GREEN;
          end
        end
        PED_WALK:  state_d = (next_dir_q == EW) ? EW_GREEN : NS_GREEN;
        default:   state_d = ALL_RED_2;
      endcase
    end
  end

`ifdef TRAFFIC_PED_EN
  // Pedestrian latch: the walk entry edge clears it and swallows any coincident request.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (enter_walk) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end
    ped_ack_d = enter_walk;
    walk_d    = (state_d == PED_WALK);
  end
`else
  // No pedestrian phase: latch stays clear so the all-red phases always go to green.
  always_comb begin
    ped_pending_d = 1'b0;
    ped_ack_d     = 1'b0;
    walk_d        = 1'b0;
  end

  logic unused_ped;
  assign unused_ped = ped_req ^ enter_walk;
`endif

  // Heads decode from the next phase so they are registered alongside the state.
  always_comb begin
    ns_light_d = ns_light_of(state_d);
    ew_light_d = ew_light_of(state_d);
  end

  // FSM state, pedestrian bookkeeping and registered outputs.
  always_ff @(posedge InputClk) begin
    if (reset) begin
      state_q       <= ALL_RED_2;
      next_dir_q    <= NS;
      ped_pending_q <= 1'b0;
      ns_light_q    <= LIGHT_RED;
      ew_light_q    <= LIGHT_RED;
      walk_q        <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      walk_q        <= walk_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign ped_ack  = ped_ack_q;

endmodule
